// File: rtl/timebin_sequencer.sv
// Multi-channel PMT time-bin sequencer.
// Cuts time into bins of factor x CLK_PER_UNIT clocks. At each bin end it
// snapshots every channel's photon counter and pulses a clear to those
// counters. It runs free-running or as a burst of n_bins bins per start.

// Per-channel snapshot register: captures the live count on a bin end and
// holds it until the next bin end.
module timebin_lane #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             snap,
  input  logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] q
);

  // hold the count captured at the last bin end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  q <= '0;
    else if (snap) q <= cnt;
  end

endmodule

module timebin_sequencer #(
  parameter int CLK_PER_UNIT = 5000,
  parameter int FACTOR_W     = 8,
  parameter int CNT_W        = 8,
  parameter int NCH          = 2,
  parameter int NBINS_W      = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [FACTOR_W-1:0]  bin_factor,
  input  logic                 mode,
  input  logic [NBINS_W-1:0]   n_bins,
  input  logic                 start,
  input  logic                 stop,
  input  logic [NCH*CNT_W-1:0] cnt_in,
  output logic                 cnt_clear,
  output logic [NCH*CNT_W-1:0] bin_data,
  output logic                 bin_valid,
  output logic [NBINS_W-1:0]   bin_index,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 led
);

  localparam int PW = (CLK_PER_UNIT > 1) ? $clog2(CLK_PER_UNIT) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_UNIT - 1);

  typedef enum logic {IDLE, RUN} state_t;

  // Run configuration captured at start; factor is also refreshed per bin.
  typedef struct packed {
    logic [FACTOR_W-1:0] factor;
    logic                mode;
    logic [NBINS_W-1:0]  n_bins;
  } cfg_t;

  state_t              state;
  cfg_t                cfg;
  logic [PW-1:0]       presc;
  logic [FACTOR_W-1:0] unit;
  logic [NBINS_W-1:0]  bin_cnt;

  logic unit_tick, last_unit, bin_end, last_bin, start_ok;

  logic [NCH-1:0][CNT_W-1:0] cnt_arr;
  logic [NCH-1:0][CNT_W-1:0] snap_arr;

  // Bin timing decode. A stop in the same cycle suppresses the bin end so
  // an aborted bin is neither captured nor cleared.
  always_comb begin
    unit_tick = (state == RUN) && (presc == PRESC_LAST);
    last_unit = (unit == cfg.factor - FACTOR_W'(1));
    bin_end   = unit_tick && last_unit && !stop;
    last_bin  = cfg.mode && (bin_cnt == cfg.n_bins - NBINS_W'(1));
    start_ok  = (bin_factor != '0) && (!mode || (n_bins != '0));
  end

  assign cnt_arr  = cnt_in;
  assign bin_data = snap_arr;

  genvar g;
  generate
    for (g = 0; g < NCH; g++) begin : g_lane
      timebin_lane #(.CNT_W(CNT_W)) u_lane (
        .clk     (clk),
        .reset_n (reset_n),
        .snap    (bin_end),
        .cnt     (cnt_arr[g]),
        .q       (snap_arr[g])
      );
    end
  endgenerate

  // Control FSM: counters, configuration latch and all strobe outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cfg       <= '0;
      presc     <= '0;
      unit      <= '0;
      bin_cnt   <= '0;
      cnt_clear <= 1'b0;
      bin_valid <= 1'b0;
      bin_index <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      led       <= 1'b0;
    end else begin
      cnt_clear <= 1'b0;
      bin_valid <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      case (state)
        IDLE: begin
          // stop in the same cycle blocks the start entirely
          if (start && !stop) begin
            if (start_ok) begin
              state      <= RUN;
              busy       <= 1'b1;
              cfg.factor <= bin_factor;
              cfg.mode   <= mode;
              cfg.n_bins <= n_bins;
              presc      <= '0;
              unit       <= '0;
              bin_cnt    <= '0;
              cnt_clear  <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end
        RUN: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            presc <= unit_tick ? '0 : presc + PW'(1);
            if (unit_tick)
              unit <= last_unit ? '0 : unit + FACTOR_W'(1);
            if (bin_end) begin
              bin_valid <= 1'b1;
              cnt_clear <= 1'b1;
              bin_index <= bin_cnt;
              bin_cnt   <= bin_cnt + NBINS_W'(1);
              led       <= ~led;
              // a zero factor at a boundary keeps the current bin length
              if (bin_factor != '0)
                cfg.factor <= bin_factor;
              if (last_bin) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_timebin_sequencer.sv
// Directed bench for timebin_sequencer with CLK_PER_UNIT=4, NCH=2, CNT_W=8.
// Stimulus is applied on the falling edge; n counts falling edges after the
// one where start was raised, so n matches "t0+n" cycle numbering.
module tb_timebin_sequencer;

  localparam int CPU = 4, FW = 8, CW = 8, NCH = 2, NW = 16;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [FW-1:0]   bin_factor = '0;
  logic            mode = 1'b0;
  logic [NW-1:0]   n_bins = '0;
  logic            start = 1'b0;
  logic            stop = 1'b0;
  logic [NCH*CW-1:0] cnt_in = '0;
  logic            cnt_clear, bin_valid, busy, done, err, led;
  logic [NCH*CW-1:0] bin_data;
  logic [NW-1:0]   bin_index;

  int       checks = 0;
  int       fails = 0;
  logic     exp_led = 1'b0;
  logic [NW-1:0] exp_idx;
  logic [4:0] exp_s;
  logic     bv;

  always #5 clk = ~clk;

  timebin_sequencer #(
    .CLK_PER_UNIT(CPU), .FACTOR_W(FW), .CNT_W(CW), .NCH(NCH), .NBINS_W(NW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bin_factor(bin_factor), .mode(mode),
    .n_bins(n_bins), .start(start), .stop(stop), .cnt_in(cnt_in),
    .cnt_clear(cnt_clear), .bin_data(bin_data), .bin_valid(bin_valid),
    .bin_index(bin_index), .busy(busy), .done(done), .err(err), .led(led)
  );

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({cnt_clear, bin_data, bin_valid, bin_index, busy, done, err, led} !== '0) begin
      fails++;
      $display("FAIL reset_hold outputs got %h exp 0",
               {cnt_clear, bin_data, bin_valid, bin_index, busy, done, err, led});
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({cnt_clear, bin_data, bin_valid, bin_index, busy, done, err, led} !== '0) begin
      fails++;
      $display("FAIL reset_release outputs got %h exp 0",
               {cnt_clear, bin_data, bin_valid, bin_index, busy, done, err, led});
    end
  endtask

  // factor=3 free-run: strobes at t0+13, +25, +37, then stop
  task automatic test_freerun();
    exp_idx = '0;
    bin_factor = 8'd3; mode = 1'b0; cnt_in = 16'h2211; start = 1'b1;
    for (int n = 1; n <= 41; n++) begin
      @(negedge clk); start = 1'b0;
      bv = (n == 13 || n == 25 || n == 37);
      exp_s = {bv, bv || n == 1, 1'b1, 1'b0, 1'b0};
      checks++;
      if ({bin_valid, cnt_clear, busy, done, err} !== exp_s) begin
        fails++;
        $display("FAIL freerun_strobes n=%0d got %b exp %b", n,
                 {bin_valid, cnt_clear, busy, done, err}, exp_s);
      end
      if (bv) begin
        exp_led = ~exp_led;
        checks++;
        if ({bin_index, bin_data, led} !== {exp_idx, 16'h2211, exp_led}) begin
          fails++;
          $display("FAIL freerun_data n=%0d got idx=%0d data=%h led=%b exp idx=%0d data=2211 led=%b",
                   n, bin_index, bin_data, led, exp_idx, exp_led);
        end
        exp_idx++;
      end
    end
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    checks++;
    if ({bin_valid, cnt_clear, busy} !== 3'b000) begin
      fails++;
      $display("FAIL freerun_stop got %b exp 000", {bin_valid, cnt_clear, busy});
    end
    repeat (2) @(negedge clk);
  endtask

  // burst factor=2 n_bins=3; mode/n_bins changes during RUN are ignored
  task automatic test_burst();
    exp_idx = '0;
    bin_factor = 8'd2; mode = 1'b1; n_bins = 16'd3; cnt_in = 16'h5A0F; start = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk); start = 1'b0;
      bv = (n == 9 || n == 17 || n == 25);
      exp_s = {bv, bv || n == 1, n < 25, n == 25, 1'b0};
      checks++;
      if ({bin_valid, cnt_clear, busy, done, err} !== exp_s) begin
        fails++;
        $display("FAIL burst_strobes n=%0d got %b exp %b", n,
                 {bin_valid, cnt_clear, busy, done, err}, exp_s);
      end
      if (bv) begin
        exp_led = ~exp_led;
        checks++;
        if ({bin_index, bin_data, led} !== {exp_idx, 16'h5A0F, exp_led}) begin
          fails++;
          $display("FAIL burst_data n=%0d got idx=%0d data=%h led=%b exp idx=%0d data=5a0f led=%b",
                   n, bin_index, bin_data, led, exp_idx, exp_led);
        end
        exp_idx++;
      end
      if (n == 3) begin mode = 1'b0; n_bins = 16'd1; end
    end
  endtask

  // illegal starts: zero factor, then burst with zero bins
  task automatic test_err();
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin bin_factor = 8'd0; mode = 1'b0; n_bins = 16'd5; end
      else        begin bin_factor = 8'd2; mode = 1'b1; n_bins = 16'd0; end
      start = 1'b1;
      for (int n = 1; n <= 4; n++) begin
        @(negedge clk); start = 1'b0;
        exp_s = {1'b0, 1'b0, 1'b0, 1'b0, n == 1};
        checks++;
        if ({bin_valid, cnt_clear, busy, done, err} !== exp_s) begin
          fails++;
          $display("FAIL err_case%0d n=%0d got %b exp %b", k, n,
                   {bin_valid, cnt_clear, busy, done, err}, exp_s);
        end
      end
    end
  endtask

  // factor 2 -> 5 mid-bin -> 0: bins of 8, 8, 20, 20 cycles
  task automatic test_factor_change();
    exp_idx = '0;
    bin_factor = 8'd2; mode = 1'b0; cnt_in = 16'h3344; start = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk); start = 1'b0;
      bv = (n == 9 || n == 17 || n == 37 || n == 57);
      exp_s = {bv, bv || n == 1, 1'b1, 1'b0, 1'b0};
      checks++;
      if ({bin_valid, cnt_clear, busy, done, err} !== exp_s) begin
        fails++;
        $display("FAIL factor_strobes n=%0d got %b exp %b", n,
                 {bin_valid, cnt_clear, busy, done, err}, exp_s);
      end
      if (bv) begin
        exp_led = ~exp_led;
        checks++;
        if ({bin_index, led} !== {exp_idx, exp_led}) begin
          fails++;
          $display("FAIL factor_index n=%0d got idx=%0d led=%b exp idx=%0d led=%b",
                   n, bin_index, led, exp_idx, exp_led);
        end
        exp_idx++;
      end
      if (n == 12) bin_factor = 8'd5;
      if (n == 20) bin_factor = 8'd0;
    end
    stop = 1'b1;
    @(negedge clk); stop = 1'b0; bin_factor = 8'd2;
    repeat (2) @(negedge clk);
  endtask

  // stop on a bin-end cycle; then a start while running
  task automatic test_stop_and_restart();
    bin_factor = 8'd2; mode = 1'b0; cnt_in = 16'hA5C3; start = 1'b1;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk); start = 1'b0; stop = 1'b0;
      exp_s = {1'b0, n == 1, n <= 8, 1'b0, 1'b0};
      checks++;
      if ({bin_valid, cnt_clear, busy, done, err} !== exp_s) begin
        fails++;
        $display("FAIL stop_binend n=%0d got %b exp %b", n,
                 {bin_valid, cnt_clear, busy, done, err}, exp_s);
      end
      if (n == 8) stop = 1'b1;
    end
    checks++;
    if (bin_data !== 16'h3344) begin
      fails++;
      $display("FAIL stop_data got %h exp 3344", bin_data);
    end

    exp_idx = '0;
    bin_factor = 8'd2; mode = 1'b1; n_bins = 16'd2; cnt_in = 16'h0102; start = 1'b1;
    for (int n = 1; n <= 24; n++) begin
      @(negedge clk); start = 1'b0;
      if (n == 6) begin bin_factor = 8'd2; mode = 1'b1; end
      bv = (n == 9 || n == 17);
      exp_s = {bv, bv || n == 1, n < 17, n == 17, 1'b0};
      checks++;
      if ({bin_valid, cnt_clear, busy, done, err} !== exp_s) begin
        fails++;
        $display("FAIL start_in_run n=%0d got %b exp %b", n,
                 {bin_valid, cnt_clear, busy, done, err}, exp_s);
      end
      if (bv) begin
        exp_led = ~exp_led;
        checks++;
        if ({bin_index, bin_data, led} !== {exp_idx, 16'h0102, exp_led}) begin
          fails++;
          $display("FAIL start_in_run_data n=%0d got idx=%0d data=%h led=%b exp idx=%0d data=0102 led=%b",
                   n, bin_index, bin_data, led, exp_idx, exp_led);
        end
        exp_idx++;
      end
      if (n == 5) begin start = 1'b1; bin_factor = 8'd1; mode = 1'b0; end
    end
  endtask

  // async reset mid-bin, then a fresh run from index 0
  task automatic test_async_reset();
    bin_factor = 8'd3; mode = 1'b0; cnt_in = 16'h7788; start = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk); start = 1'b0;
    end
    checks++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL areset_pre busy got %b exp 1", busy);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({cnt_clear, bin_data, bin_valid, bin_index, busy, done, err, led} !== '0) begin
      fails++;
      $display("FAIL areset_now outputs got %h exp 0",
               {cnt_clear, bin_data, bin_valid, bin_index, busy, done, err, led});
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    exp_led = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk); start = 1'b0;
      bv = (n == 13);
      exp_s = {bv, bv || n == 1, 1'b1, 1'b0, 1'b0};
      checks++;
      if ({bin_valid, cnt_clear, busy, done, err} !== exp_s) begin
        fails++;
        $display("FAIL areset_rerun n=%0d got %b exp %b", n,
                 {bin_valid, cnt_clear, busy, done, err}, exp_s);
      end
      if (bv) begin
        exp_led = ~exp_led;
        checks++;
        if ({bin_index, bin_data, led} !== {16'd0, 16'h7788, exp_led}) begin
          fails++;
          $display("FAIL areset_data got idx=%0d data=%h led=%b exp idx=0 data=7788 led=%b",
                   bin_index, bin_data, led, exp_led);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_freerun();
    test_burst();
    test_err();
    test_factor_change();
    test_stop_and_restart();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
